// File: rtl/spi_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_sram_pkg
// Purpose  : Shared types and constants for the SPI serial-SRAM responder:
//            FSM state encoding, SPI opcodes and mode-register field codes.
// Revision : 1.0  initial release
// ============================================================================
package spi_sram_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    WDATA  = 3'd3,
    RDATA  = 3'd4,
    IGNORE = 3'd5
  } state_e;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_RDMR  = 8'h05;
  localparam logic [7:0] CMD_WRMR  = 8'h01;

  // Mode register bits [7:6] select the transfer/wrap behaviour.
  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_SEQ  = 2'b01;
  localparam logic [1:0] MODE_PAGE = 2'b10;

  localparam logic [7:0] MODE_REG_RESET = 8'h40;

  // Page-mode wrap boundary: 32-byte pages.
  localparam int PAGE_BITS = 5;

endpackage
`default_nettype wire

// File: rtl/spi_sram_sync.sv
`default_nettype none
// ============================================================================
// Module   : spi_sram_sync
// Purpose  : Brings the asynchronous SPI pins into the clk domain and detects
//            SCK edges on the synchronized copy.
// Ports    : clk, rst_n        system clock, async active-low reset
//            sck_i/cs_n_i/mosi_i raw SPI pins
//            sck_rise_o/sck_fall_o one-cycle edge pulses
//            cs_active_o       synchronized chip select, active high
//            mosi_o            synchronized MOSI, aligned with the edge pulses
// Revision : 1.0  initial release
// ============================================================================
module spi_sram_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sck_i,
  input  logic cs_n_i,
  input  logic mosi_i,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic cs_active_o,
  output logic mosi_o
);

  logic [SYNC_STAGES-1:0] sck_q;
  logic [SYNC_STAGES-1:0] cs_n_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   sck_prev_q;

  // CS_N chain resets high so the responder starts deselected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q      <= '0;
      cs_n_q     <= '1;
      mosi_q     <= '0;
      sck_prev_q <= 1'b0;
    end else begin
      sck_q      <= {sck_q[SYNC_STAGES-2:0], sck_i};
      cs_n_q     <= {cs_n_q[SYNC_STAGES-2:0], cs_n_i};
      mosi_q     <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
      sck_prev_q <= sck_q[SYNC_STAGES-1];
    end
  end

  // MOSI passes through the same depth as SCK, so at a detected rise it
  // still holds the bit the initiator set up before that rise.
  assign sck_rise_o  =  sck_q[SYNC_STAGES-1] & ~sck_prev_q;
  assign sck_fall_o  = ~sck_q[SYNC_STAGES-1] &  sck_prev_q;
  assign cs_active_o = ~cs_n_q[SYNC_STAGES-1];
  assign mosi_o      =  mosi_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/spi_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : spi_sram_responder
// Purpose  : SPI mode-0 responder emulating a 23LC-style serial SRAM on top
//            of an external block RAM (1-cycle read latency).
// Ports    : clk, rst_n                  system clock, async active-low reset
//            spi_sck/spi_cs_n/spi_mosi   SPI inputs from the initiator
//            spi_miso, spi_miso_oe       read data and its drive enable
//            mem_addr/mem_wdata/mem_we   BRAM write side
//            mem_re/mem_rdata            BRAM read strobe and returned data
// Options  : SPI_SRAM_MODE_REG_EN adds RDMR/WRMR and byte/page/sequential
//            modes; without it 0x05/0x01 are ignored and access is sequential.
// Revision : 1.0  initial release
// ============================================================================
module spi_sram_responder
  import spi_sram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_sck,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [7:0]            mem_rdata
);

  logic sck_rise, sck_fall, cs_active, mosi;

  spi_sram_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .sck_i       (spi_sck),
    .cs_n_i      (spi_cs_n),
    .mosi_i      (spi_mosi),
    .sck_rise_o  (sck_rise),
    .sck_fall_o  (sck_fall),
    .cs_active_o (cs_active),
    .mosi_o      (mosi)
  );

  state_e                state_q, state_d;
  logic [4:0]            bit_cnt_q, bit_cnt_d;    // rises within CMD/ADDR/byte
  logic [2:0]            fall_cnt_q, fall_cnt_d;  // falls within a read byte
  logic [6:0]            rx_q, rx_d;
  logic [7:0]            tx_q, tx_d;
  logic [7:0]            next_q, next_d;          // prefetched next read byte
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]            mem_wdata_q, mem_wdata_d;
  logic                  mem_we_q, mem_we_d;
  logic                  mem_re_q, mem_re_d;
  logic                  rd_pend_q, rd_pend_d;    // mem_rdata valid this cycle
  logic                  is_write_q, is_write_d;
  logic                  miso_q, miso_d;

  logic [7:0]            rx_shift;
  logic [ADDR_WIDTH-1:0] addr_shift;
  logic [1:0]            mode_field;
  logic                  mem_xfer;                // transfer targets the BRAM

`ifdef SPI_SRAM_MODE_REG_EN
  logic [7:0] mode_q, mode_d;
  logic       is_mode_q, is_mode_d;
  assign mode_field = mode_q[7:6];
  assign mem_xfer   = ~is_mode_q;
`else
  assign mode_field = MODE_SEQ;
  assign mem_xfer   = 1'b1;
`endif

  assign rx_shift   = {rx_q, mosi};
  // Shifting all 24 address bits through a narrower register keeps only the
  // low ADDR_WIDTH bits once the last bit arrives.
  assign addr_shift = {addr_q[ADDR_WIDTH-2:0], mosi};

  function automatic logic [ADDR_WIDTH-1:0] addr_inc(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [1:0]            mode
  );
    logic [ADDR_WIDTH-1:0] n;
    n = a + ADDR_WIDTH'(1);
    if (mode == MODE_PAGE) n[ADDR_WIDTH-1:PAGE_BITS] = a[ADDR_WIDTH-1:PAGE_BITS];
    return n;
  endfunction

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    fall_cnt_d  = fall_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    next_d      = next_q;
    addr_d      = addr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    rd_pend_d   = mem_re_q;
    is_write_d  = is_write_q;
    miso_d      = miso_q;
`ifdef SPI_SRAM_MODE_REG_EN
    mode_d      = mode_q;
    is_mode_d   = is_mode_q;
`endif

    if (!cs_active) begin
      // Deselect aborts everything; a partial write byte is simply dropped.
      state_d    = IDLE;
      bit_cnt_d  = '0;
      fall_cnt_d = '0;
      miso_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = CMD;
          bit_cnt_d = '0;
          rx_d      = '0;
        end

        CMD: begin
          if (sck_rise) begin
            rx_d      = rx_shift[6:0];
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d  = '0;
              fall_cnt_d = '0;
              state_d    = IGNORE;
`ifdef SPI_SRAM_MODE_REG_EN
              is_mode_d  = 1'b0;
`endif
              if (rx_shift == CMD_READ) begin
                state_d    = ADDR;
                is_write_d = 1'b0;
              end else if (rx_shift == CMD_WRITE) begin
                state_d    = ADDR;
                is_write_d = 1'b1;
              end
`ifdef SPI_SRAM_MODE_REG_EN
              else if (rx_shift == CMD_RDMR) begin
                state_d   = RDATA;
                is_mode_d = 1'b1;
                tx_d      = mode_q;
                next_d    = mode_q;
              end else if (rx_shift == CMD_WRMR) begin
                state_d   = WDATA;
                is_mode_d = 1'b1;
              end
`endif
            end
          end
        end

        ADDR: begin
          if (sck_rise) begin
            addr_d    = addr_shift;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_d = '0;
              if (is_write_q) begin
                state_d = WDATA;
              end else begin
                mem_re_d   = 1'b1;
                mem_addr_d = addr_shift;
              end
            end
          end else if (rd_pend_q) begin
            // First read byte arrives; the address moves on so the next
            // prefetch already points at the following location.
            tx_d       = mem_rdata;
            addr_d     = addr_inc(addr_q, mode_field);
            state_d    = RDATA;
            bit_cnt_d  = '0;
            fall_cnt_d = '0;
          end
        end

        WDATA: begin
          if (sck_rise) begin
            rx_d      = rx_shift[6:0];
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = '0;
`ifdef SPI_SRAM_MODE_REG_EN
              if (is_mode_q) begin
                mode_d  = rx_shift;
                state_d = IGNORE;
              end else
`endif
              begin
                mem_we_d    = 1'b1;
                mem_wdata_d = rx_shift;
                mem_addr_d  = addr_q;
                addr_d      = addr_inc(addr_q, mode_field);
                if (mode_field == MODE_BYTE) state_d = IGNORE;
              end
            end
          end
        end

        RDATA: begin
          if (sck_fall) begin
            miso_d = tx_q[7];
            // The 8th fall drives the last bit and swaps in the prefetched
            // byte so its MSB is ready for the following fall.
            if (fall_cnt_q == 3'd7) begin
              tx_d       = next_q;
              fall_cnt_d = '0;
            end else begin
              tx_d       = {tx_q[6:0], 1'b0};
              fall_cnt_d = fall_cnt_q + 3'd1;
            end
          end
          if (sck_rise) begin
            bit_cnt_d = (bit_cnt_q == 5'd7) ? 5'd0 : bit_cnt_q + 5'd1;
            if (mode_field == MODE_BYTE) begin
              // Leave only after the initiator has sampled the last bit.
              if (bit_cnt_q == 5'd7) state_d = IGNORE;
            end else if (bit_cnt_q == 5'd6 && mem_xfer) begin
              mem_re_d   = 1'b1;
              mem_addr_d = addr_q;
              addr_d     = addr_inc(addr_q, mode_field);
            end
          end
          if (rd_pend_q) next_d = mem_rdata;
        end

        IGNORE: begin
          state_d = IGNORE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      fall_cnt_q  <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      next_q      <= '0;
      addr_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      rd_pend_q   <= 1'b0;
      is_write_q  <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      fall_cnt_q  <= fall_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      next_q      <= next_d;
      addr_q      <= addr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      rd_pend_q   <= rd_pend_d;
      is_write_q  <= is_write_d;
      miso_q      <= miso_d;
    end
  end

`ifdef SPI_SRAM_MODE_REG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= MODE_REG_RESET;
      is_mode_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      is_mode_q <= is_mode_d;
    end
  end
`endif

  assign spi_miso_oe = (state_q == RDATA);
  assign spi_miso    = miso_q & spi_miso_oe;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_we      = mem_we_q;
  assign mem_re      = mem_re_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_sram_responder
// Purpose  : Directed self-checking bench for spi_sram_responder with a
//            behavioural 64 KiB BRAM. Mode-register checks are compiled in
//            when SPI_SRAM_MODE_REG_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_spi_sram_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spi_sck, spi_cs_n, spi_mosi;
  logic        spi_miso, spi_miso_oe;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_we, mem_re;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_sram_responder #(
    .ADDR_WIDTH  (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_sck     (spi_sck),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_re      (mem_re),
    .mem_rdata   (mem_rdata)
  );

  // Behavioural BRAM and strobe monitors.
  logic [7:0]  mem [0:65535];
  logic [15:0] we_addr_log [$];
  logic [7:0]  we_data_log [$];
  int we_cnt = 0, re_cnt = 0, both_cnt = 0, oe_cnt = 0;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      we_addr_log.push_back(mem_addr);
      we_data_log.push_back(mem_wdata);
      we_cnt++;
    end
    if (mem_re) begin
      mem_rdata <= mem[mem_addr];
      re_cnt++;
    end
    if (mem_we && mem_re) both_cnt++;
    if (spi_miso_oe) oe_cnt++;
  end

  logic oe_and, oe_or;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Sends the top nbits of tx MSB first; MISO is sampled just before each
  // rise. Tracks spi_miso_oe at those sample points.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx     = 8'h00;
    oe_and = 1'b1;
    oe_or  = 1'b0;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = tx[i];
      repeat (5) @(negedge clk);
      rx[i]  = spi_miso;
      oe_and = oe_and & spi_miso_oe;
      oe_or  = oe_or  | spi_miso_oe;
      spi_sck = 1'b1;
      repeat (5) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx);
  endtask

  task automatic spi_start();
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic spi_stop();
    repeat (3) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic spi_cmd_addr(input logic [7:0] cmd, input logic [23:0] a);
    logic [7:0] d;
    spi_byte(cmd, d);
    spi_byte(a[23:16], d);
    spi_byte(a[15:8], d);
    spi_byte(a[7:0], d);
  endtask

  initial begin
    logic [7:0] r;
    int base, c0, c1;

    spi_sck = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0; rst_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_oe",    {31'd0, spi_miso_oe}, 32'd0);
    chk("rst_miso",  {31'd0, spi_miso},    32'd0);
    chk("rst_we",    {31'd0, mem_we},      32'd0);
    chk("rst_re",    {31'd0, mem_re},      32'd0);
    chk("rst_addr",  {16'd0, mem_addr},    32'd0);
    chk("rst_wdata", {24'd0, mem_wdata},   32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Write 0xA5, 0x3C at 0x0010.
    base = we_addr_log.size();
    spi_start(); spi_cmd_addr(8'h02, 24'h000010);
    spi_byte(8'hA5, r); spi_byte(8'h3C, r); spi_stop();
    chk("wr_count", we_addr_log.size() - base, 32'd2);
    if (we_addr_log.size() >= base + 2) begin
      chk("wr_addr0", {16'd0, we_addr_log[base]},     32'h0010);
      chk("wr_data0", {24'd0, we_data_log[base]},     32'hA5);
      chk("wr_addr1", {16'd0, we_addr_log[base + 1]}, 32'h0011);
      chk("wr_data1", {24'd0, we_data_log[base + 1]}, 32'h3C);
    end

    // Read back two bytes.
    spi_start(); spi_cmd_addr(8'h03, 24'h000010);
    spi_byte(8'h00, r); chk("rd_byte0", {24'd0, r}, 32'hA5); chk("rd_oe0", {31'd0, oe_and}, 32'd1);
    spi_byte(8'h00, r); chk("rd_byte1", {24'd0, r}, 32'h3C); chk("rd_oe1", {31'd0, oe_and}, 32'd1);
    spi_stop();

    // Address wrap 0xFFFF -> 0x0000 in one burst.
    base = we_addr_log.size();
    spi_start(); spi_cmd_addr(8'h02, 24'h00FFFF);
    spi_byte(8'h11, r); spi_byte(8'h22, r); spi_stop();
    chk("wrap_wr_count", we_addr_log.size() - base, 32'd2);
    if (we_addr_log.size() >= base + 2) begin
      chk("wrap_wr_addr0", {16'd0, we_addr_log[base]},     32'hFFFF);
      chk("wrap_wr_addr1", {16'd0, we_addr_log[base + 1]}, 32'h0000);
    end
    spi_start(); spi_cmd_addr(8'h03, 24'h00FFFF);
    spi_byte(8'h00, r); chk("wrap_rd0", {24'd0, r}, 32'h11);
    spi_byte(8'h00, r); chk("wrap_rd1", {24'd0, r}, 32'h22);
    spi_stop();

    // Abort: partial byte must not be written.
    spi_start(); spi_cmd_addr(8'h02, 24'h000020); spi_byte(8'h77, r); spi_stop();
    base = we_addr_log.size();
    spi_start(); spi_cmd_addr(8'h02, 24'h000020); spi_bits(8'h99, 5, r); spi_stop();
    chk("abort_no_we", we_addr_log.size() - base, 32'd0);
    spi_start(); spi_cmd_addr(8'h03, 24'h000020);
    spi_byte(8'h00, r); chk("abort_old_val", {24'd0, r}, 32'h77);
    spi_stop();

    // Unknown command: no drive, no strobes.
    c0 = oe_cnt; c1 = we_cnt + re_cnt;
    spi_start(); spi_byte(8'h9F, r); spi_byte(8'h00, r); spi_byte(8'hFF, r); spi_byte(8'h00, r); spi_stop();
    chk("unk_oe", oe_cnt - c0, 32'd0);
    chk("unk_strobes", we_cnt + re_cnt - c1, 32'd0);

    // Reset asserted mid-read.
    spi_start(); spi_cmd_addr(8'h03, 24'h000010); spi_bits(8'h00, 3, r);
    chk("mid_oe_before", {31'd0, spi_miso_oe}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_oe",    {31'd0, spi_miso_oe}, 32'd0);
    chk("mid_rst_miso",  {31'd0, spi_miso},    32'd0);
    chk("mid_rst_we",    {31'd0, mem_we},      32'd0);
    chk("mid_rst_re",    {31'd0, mem_re},      32'd0);
    chk("mid_rst_addr",  {16'd0, mem_addr},    32'd0);
    chk("mid_rst_wdata", {24'd0, mem_wdata},   32'd0);
    spi_cs_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    spi_start(); spi_cmd_addr(8'h03, 24'h000011);
    spi_byte(8'h00, r); chk("post_rst_rd", {24'd0, r}, 32'h3C);
    spi_stop();

`ifdef SPI_SRAM_MODE_REG_EN
    spi_start(); spi_byte(8'h05, r); spi_byte(8'h00, r); spi_stop();
    chk("rdmr_reset", {24'd0, r}, 32'h40);
    spi_start(); spi_byte(8'h01, r); spi_byte(8'h00, r); spi_stop();
    spi_start(); spi_byte(8'h05, r); spi_byte(8'h00, r); spi_stop();
    chk("rdmr_after_wrmr", {24'd0, r}, 32'h00);
    spi_start(); spi_cmd_addr(8'h03, 24'h000010);
    spi_byte(8'h00, r); chk("byte_rd0", {24'd0, r}, 32'hA5); chk("byte_oe0", {31'd0, oe_and}, 32'd1);
    spi_byte(8'h00, r); chk("byte_oe1", {31'd0, oe_or}, 32'd0); chk("byte_rd1", {24'd0, r}, 32'h00);
    spi_stop();
`endif

    chk("we_re_overlap", both_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
